// File: rtl/tetris_input_ctrl_pkg.sv
// Shared types for the Tetris input controller: move command encoding, HID key
// codes, the pending-bit layout, command priority and the gravity period rule.
package tetris_input_ctrl_pkg;

  typedef enum logic [2:0] {
    CMD_NONE      = 3'd0,
    CMD_LEFT      = 3'd1,
    CMD_RIGHT     = 3'd2,
    CMD_DOWN      = 3'd3,
    CMD_ROT_L     = 3'd4,
    CMD_ROT_R     = 3'd5,
    CMD_HARD_DROP = 3'd6
  } move_t;

  localparam logic [7:0] HID_LEFT      = 8'h50;
  localparam logic [7:0] HID_RIGHT     = 8'h4F;
  localparam logic [7:0] HID_DOWN      = 8'h51;
  localparam logic [7:0] HID_ROT_R     = 8'h52;
  localparam logic [7:0] HID_ROT_L     = 8'h1D;
  localparam logic [7:0] HID_HARD_DROP = 8'h2C;

  localparam int NUM_CMDS  = 6;
  localparam int IDX_LEFT  = 0;
  localparam int IDX_RIGHT = 1;
  localparam int IDX_DOWN  = 2;
  localparam int IDX_ROT_L = 3;
  localparam int IDX_ROT_R = 4;
  localparam int IDX_HARD  = 5;

  function automatic logic [NUM_CMDS-1:0] cmd_mask(move_t c);
    logic [NUM_CMDS-1:0] m;
    m = '0;
    case (c)
      CMD_LEFT:      m[IDX_LEFT]  = 1'b1;
      CMD_RIGHT:     m[IDX_RIGHT] = 1'b1;
      CMD_DOWN:      m[IDX_DOWN]  = 1'b1;
      CMD_ROT_L:     m[IDX_ROT_L] = 1'b1;
      CMD_ROT_R:     m[IDX_ROT_R] = 1'b1;
      CMD_HARD_DROP: m[IDX_HARD]  = 1'b1;
      default:       m = '0;
    endcase
    return m;
  endfunction

  // Highest-priority command wins: HARD_DROP > ROT_R > ROT_L > LEFT > RIGHT > DOWN.
  function automatic move_t pick_cmd(logic [NUM_CMDS-1:0] avail);
    if (avail[IDX_HARD])       return CMD_HARD_DROP;
    else if (avail[IDX_ROT_R]) return CMD_ROT_R;
    else if (avail[IDX_ROT_L]) return CMD_ROT_L;
    else if (avail[IDX_LEFT])  return CMD_LEFT;
    else if (avail[IDX_RIGHT]) return CMD_RIGHT;
    else if (avail[IDX_DOWN])  return CMD_DOWN;
    else                       return CMD_NONE;
  endfunction

  // Signed arithmetic so high levels clamp to 1 instead of wrapping.
  function automatic logic [15:0] gravity_period(int base, int step, int level);
    int p;
    p = base - level * step;
    if (p < 1) p = 1;
    return p[15:0];
  endfunction

endpackage

// File: rtl/tetris_input_ctrl_key_repeat.sv
// Delayed auto-shift / auto-repeat generator for one held key.
// req_o is combinational so a press or tick reaches the output register at once.
module key_repeat
  import tetris_input_ctrl_pkg::*;
#(
  parameter int DAS_FRAMES = 10,
  parameter int ARR_FRAMES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic held_i,
  input  logic tick_i,
  output logic req_o
);

  localparam int CNT_MAX = (DAS_FRAMES > ARR_FRAMES) ? DAS_FRAMES : ARR_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DAS, ST_REPEAT} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             held_q;
  logic             press;
  logic             expire;

  assign press  = held_i & ~held_q;
  assign expire = tick_i && (cnt_q == CNT_W'(1));
  assign req_o  = held_i && (((state_q == ST_IDLE) && press) ||
                             ((state_q != ST_IDLE) && expire));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      held_q  <= 1'b0;
    end else begin
      held_q <= held_i;
      if (!held_i) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (press) begin
              state_q <= ST_DAS;
              cnt_q   <= CNT_W'(DAS_FRAMES);
            end
          end
          ST_DAS, ST_REPEAT: begin
            if (expire) begin
              state_q <= ST_REPEAT;
              cnt_q   <= CNT_W'(ARR_FRAMES);
            end else if (tick_i) begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/tetris_input_ctrl.sv
// Keycode-to-move-command front end with DAS/ARR, gravity and a valid/ready output.
// Optional TETRIS_INPUT_STATS_EN adds a saturating count of coalesced requests.
module tetris_input_ctrl
  import tetris_input_ctrl_pkg::*;
#(
  parameter int NUM_KEYS     = 4,
  parameter int DAS_FRAMES   = 10,
  parameter int ARR_FRAMES   = 2,
  parameter int GRAVITY_BASE = 48,
  parameter int GRAVITY_STEP = 3,
  parameter int LEVEL_W      = 5
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [8*NUM_KEYS-1:0] keycode_i,
  input  logic                  frame_vs_i,
  input  logic [LEVEL_W-1:0]    level_i,
  input  logic                  piece_locked_i,
  input  logic                  move_ready_i,
  output logic                  move_valid_o,
  output move_t                 move_cmd_o,
  output logic [15:0]           drop_count_o
);

  logic                  vs_q1, vs_q2, vs_q3;
  logic                  tick;
  logic [8*NUM_KEYS-1:0] keycode_q;
  logic [2:0]            edge_prev_q;
  logic                  held_left, held_right, held_down;
  logic                  held_rot_l, held_rot_r, held_hard;
  logic                  req_left, req_right, req_soft;
  logic [15:0]           grav_period, grav_q, grav_d;
  logic                  grav_req;
  logic [NUM_CMDS-1:0]   req_vec, pend_kept, avail, pending_q, pending_d;
  logic                  valid_q, valid_d;
  move_t                 cmd_q, cmd_d;

  function automatic logic key_held(logic [8*NUM_KEYS-1:0] codes, logic [7:0] key);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (codes[8*i +: 8] == key) hit = 1'b1;
    end
    return hit;
  endfunction

  assign tick       = vs_q2 & ~vs_q3;
  assign held_left  = key_held(keycode_q, HID_LEFT);
  assign held_right = key_held(keycode_q, HID_RIGHT);
  assign held_down  = key_held(keycode_q, HID_DOWN);
  assign held_rot_l = key_held(keycode_q, HID_ROT_L);
  assign held_rot_r = key_held(keycode_q, HID_ROT_R);
  assign held_hard  = key_held(keycode_q, HID_HARD_DROP);

  // Opposing directions cancel; releasing one then looks like a fresh press of the other.
  key_repeat #(.DAS_FRAMES(DAS_FRAMES), .ARR_FRAMES(ARR_FRAMES)) u_left (
    .clk_i(clk_i), .reset_i(reset_i), .held_i(held_left & ~held_right),
    .tick_i(tick), .req_o(req_left)
  );
  key_repeat #(.DAS_FRAMES(DAS_FRAMES), .ARR_FRAMES(ARR_FRAMES)) u_right (
    .clk_i(clk_i), .reset_i(reset_i), .held_i(held_right & ~held_left),
    .tick_i(tick), .req_o(req_right)
  );
  key_repeat #(.DAS_FRAMES(DAS_FRAMES), .ARR_FRAMES(ARR_FRAMES)) u_down (
    .clk_i(clk_i), .reset_i(reset_i), .held_i(held_down),
    .tick_i(tick), .req_o(req_soft)
  );

  assign grav_period = gravity_period(GRAVITY_BASE, GRAVITY_STEP, int'(level_i));

  always_comb begin
    grav_d   = grav_q;
    grav_req = 1'b0;
    if (piece_locked_i) begin
      grav_d = grav_period;
    end else if (tick) begin
      if (grav_q <= 16'd1) begin
        grav_req = 1'b1;
        grav_d   = grav_period;
      end else begin
        grav_d = grav_q - 16'd1;
      end
    end
  end

  assign req_vec = {held_hard  & ~edge_prev_q[2],
                    held_rot_r & ~edge_prev_q[1],
                    held_rot_l & ~edge_prev_q[0],
                    req_soft | grav_req,
                    req_right,
                    req_left};

  // A lock discards any DOWN still waiting from before the piece landed.
  assign pend_kept = pending_q & ~(piece_locked_i ? cmd_mask(CMD_DOWN) : '0);
  assign avail     = pend_kept | req_vec;

  always_comb begin
    pending_d = avail;
    valid_d   = valid_q;
    cmd_d     = cmd_q;
    if (!valid_q || move_ready_i) begin
      cmd_d     = pick_cmd(avail);
      valid_d   = (avail != '0);
      pending_d = avail & ~cmd_mask(cmd_d);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vs_q1       <= 1'b0;
      vs_q2       <= 1'b0;
      vs_q3       <= 1'b0;
      keycode_q   <= '0;
      edge_prev_q <= '0;
      grav_q      <= grav_period;
      pending_q   <= '0;
      valid_q     <= 1'b0;
      cmd_q       <= CMD_NONE;
    end else begin
      vs_q1       <= frame_vs_i;
      vs_q2       <= vs_q1;
      vs_q3       <= vs_q2;
      keycode_q   <= keycode_i;
      edge_prev_q <= {held_hard, held_rot_r, held_rot_l};
      grav_q      <= grav_d;
      pending_q   <= pending_d;
      valid_q     <= valid_d;
      cmd_q       <= cmd_d;
    end
  end

  assign move_valid_o = valid_q;
  assign move_cmd_o   = cmd_q;

`ifdef TETRIS_INPUT_STATS_EN
  logic [15:0] drop_q;
  logic [2:0]  coalesced;
  logic [16:0] drop_sum;

  assign coalesced = 3'($countones(req_vec & pend_kept));
  assign drop_sum  = {1'b0, drop_q} + 17'(coalesced);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign drop_count_o = drop_q;
`else
  assign drop_count_o = '0;
`endif

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Self-checking bench for tetris_input_ctrl: directed scenarios plus randomized
// traffic, every cycle compared against a tick/frame-level behavioural model.
module tb_tetris_input_ctrl;
  import tetris_input_ctrl_pkg::*;

  localparam int DAS   = 10;
  localparam int ARR   = 2;
  localparam int GBASE = 48;
  localparam int GSTEP = 3;
`ifdef TETRIS_INPUT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam move_t PRIO[6] = '{CMD_HARD_DROP, CMD_ROT_R, CMD_ROT_L,
                                CMD_LEFT, CMD_RIGHT, CMD_DOWN};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] keycode = '0;
  logic        frame_vs = 1'b0;
  logic [4:0]  level = '0;
  logic        piece_locked = 1'b0;
  logic        move_ready = 1'b1;
  logic        move_valid;
  move_t       move_cmd;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  tetris_input_ctrl dut (
    .clk_i(clk), .reset_i(reset), .keycode_i(keycode), .frame_vs_i(frame_vs),
    .level_i(level), .piece_locked_i(piece_locked), .move_ready_i(move_ready),
    .move_valid_o(move_valid), .move_cmd_o(move_cmd), .drop_count_o(drop_count)
  );

  int testsRun = 0;
  int failCount = 0;

  // Model state: input history, per-direction ticks held, gravity ticks, pending set.
  logic        sv0, sv1, sv2;
  logic [31:0] kcCur, kcPrev;
  bit          active[3];
  int          heldTicks[3];
  int          gTicks, gPeriod;
  bit          pend[7];
  bit          mValid;
  move_t       mCmd;
  int          mDrops;
  int          seen[7];

  function automatic int periodFor(int lvl);
    int p;
    p = GBASE - lvl * GSTEP;
    return (p < 1) ? 1 : p;
  endfunction

  function automatic bit has(logic [31:0] kc, logic [7:0] code);
    for (int i = 0; i < 4; i++) if (kc[8*i +: 8] == code) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelEdge();
    bit    tick, r, found;
    bit    req[7];
    bit    cur[3], prev[3];
    move_t keyCmd[3];
    keyCmd = '{CMD_LEFT, CMD_RIGHT, CMD_DOWN};
    if (reset) begin
      sv0 = 0; sv1 = 0; sv2 = 0; kcCur = '0; kcPrev = '0;
      for (int k = 0; k < 3; k++) begin active[k] = 0; heldTicks[k] = 0; end
      gTicks = 0; gPeriod = periodFor(int'(level));
      for (int c = 0; c < 7; c++) pend[c] = 0;
      mValid = 0; mCmd = CMD_NONE; mDrops = 0;
      return;
    end
    tick = sv1 && !sv2;
    cur[0]  = has(kcCur, 8'h50) && !has(kcCur, 8'h4F);
    prev[0] = has(kcPrev, 8'h50) && !has(kcPrev, 8'h4F);
    cur[1]  = has(kcCur, 8'h4F) && !has(kcCur, 8'h50);
    prev[1] = has(kcPrev, 8'h4F) && !has(kcPrev, 8'h50);
    cur[2]  = has(kcCur, 8'h51);
    prev[2] = has(kcPrev, 8'h51);
    for (int c = 0; c < 7; c++) req[c] = 0;
    for (int k = 0; k < 3; k++) begin
      r = 0;
      if (!cur[k]) active[k] = 0;
      else if (!prev[k]) begin active[k] = 1; heldTicks[k] = 0; r = 1; end
      else if (active[k] && tick) begin
        heldTicks[k]++;
        r = (heldTicks[k] == DAS) || (heldTicks[k] > DAS && (heldTicks[k] - DAS) % ARR == 0);
      end
      req[int'(keyCmd[k])] = r;
    end
    req[int'(CMD_ROT_L)]     = has(kcCur, 8'h1D) && !has(kcPrev, 8'h1D);
    req[int'(CMD_ROT_R)]     = has(kcCur, 8'h52) && !has(kcPrev, 8'h52);
    req[int'(CMD_HARD_DROP)] = has(kcCur, 8'h2C) && !has(kcPrev, 8'h2C);
    if (piece_locked) begin
      gTicks = 0; gPeriod = periodFor(int'(level)); pend[int'(CMD_DOWN)] = 0;
    end else if (tick) begin
      gTicks++;
      if (gTicks == gPeriod) begin
        req[int'(CMD_DOWN)] = 1; gTicks = 0; gPeriod = periodFor(int'(level));
      end
    end
    for (int c = 1; c < 7; c++) if (req[c]) begin
      if (pend[c]) mDrops++;
      pend[c] = 1;
    end
    if (!mValid || move_ready) begin
      mValid = 0; mCmd = CMD_NONE; found = 0;
      for (int p = 0; p < 6; p++) if (!found && pend[int'(PRIO[p])]) begin
        found = 1; mValid = 1; mCmd = PRIO[p]; pend[int'(PRIO[p])] = 0;
      end
    end
    sv2 = sv1; sv1 = sv0; sv0 = frame_vs;
    kcPrev = kcCur; kcCur = keycode;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("valid", 32'(move_valid), 32'(mValid));
    checkOutput("cmd", 32'(move_cmd), 32'(mCmd));
    checkOutput("drops", 32'(drop_count), STATS ? 32'((mDrops > 65535) ? 65535 : mDrops) : 32'd0);
    if (move_valid && move_ready) seen[int'(move_cmd)]++;
  endtask

  task automatic clearSeen();
    for (int c = 0; c < 7; c++) seen[c] = 0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    clearSeen();
  endtask

  // One frame = 4 cycles; lock is raised only in the gravity tick cycle of frame lockFrame.
  task automatic runFrames(input int n, input int lockFrame);
    for (int f = 0; f < n; f++) begin
      for (int s = 0; s < 4; s++) begin
        frame_vs = (s < 2);
        piece_locked = (f == lockFrame) && sv1 && !sv2;
        applyStimulus();
      end
    end
    piece_locked = 1'b0;
  endtask

  function automatic logic [31:0] randomKeys();
    logic [7:0]  pool[8];
    logic [31:0] kc;
    pool = '{8'h00, 8'h50, 8'h4F, 8'h51, 8'h52, 8'h1D, 8'h2C, 8'h04};
    kc = '0;
    for (int i = 0; i < 4; i++) kc[8*i +: 8] = ($urandom_range(0, 1) == 0) ? 8'h00 : pool[$urandom_range(0, 7)];
    return kc;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int phase, fperiod;
    doReset();
    checkOutput("reset_valid", 32'(move_valid), 32'd0);
    checkOutput("reset_cmd", 32'(move_cmd), 32'(CMD_NONE));
    checkOutput("reset_drops", 32'(drop_count), 32'd0);

    // Gravity at level 0 fires once at the 48th tick.
    runFrames(47, -1);
    checkOutput("grav_before48", 32'(seen[int'(CMD_DOWN)]), 32'd0);
    runFrames(13, -1);
    checkOutput("grav_at48", 32'(seen[int'(CMD_DOWN)]), 32'd1);
    checkOutput("grav_only", 32'(seen[1] + seen[2] + seen[4] + seen[5] + seen[6]), 32'd0);

    // LEFT held: press, then ticks 10, 12, 14; nothing after release.
    doReset();
    keycode = 32'h0000_0050;
    runFrames(15, -1);
    checkOutput("das_left", 32'(seen[int'(CMD_LEFT)]), 32'd4);
    keycode = '0;
    runFrames(10, -1);
    checkOutput("left_release", 32'(seen[int'(CMD_LEFT)]), 32'd4);

    // LEFT+RIGHT cancel; dropping LEFT is a fresh RIGHT press.
    doReset();
    keycode = 32'h0000_4F50;
    runFrames(30, -1);
    checkOutput("lr_cancel", 32'(seen[int'(CMD_LEFT)] + seen[int'(CMD_RIGHT)]), 32'd0);
    keycode = 32'h0000_004F;
    applyStimulus();
    applyStimulus();
    checkOutput("right_latency_valid", 32'(move_valid), 32'd1);
    checkOutput("right_latency_cmd", 32'(move_cmd), 32'(CMD_RIGHT));

    // Back-pressure holds HARD_DROP, then ROT_R follows.
    move_ready = 1'b0;
    keycode = '0;
    doReset();
    keycode = 32'h0000_522C;
    applyStimulus();
    applyStimulus();
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("hold_hard", 32'(move_cmd), 32'(CMD_HARD_DROP));
    end
    move_ready = 1'b1;
    applyStimulus();
    move_ready = 1'b0;
    checkOutput("next_rot_r", 32'(move_cmd), 32'(CMD_ROT_R));
    applyStimulus();
    checkOutput("hold_rot_r", 32'(move_cmd), 32'(CMD_ROT_R));

    // Level 20 clamps the period to 1; one locked expiry loses its DOWN.
    move_ready = 1'b1;
    keycode = '0;
    level = 5'd20;
    doReset();
    runFrames(8, 3);
    checkOutput("clamp_lock_down", 32'(seen[int'(CMD_DOWN)]), 32'd7);

    // Reset mid-handshake with LEFT pending, after one coalesced LEFT.
    level = 5'd0;
    move_ready = 1'b0;
    doReset();
    keycode = 32'h0000_002C;
    applyStimulus(); applyStimulus();
    keycode = 32'h0000_2C50;
    applyStimulus(); applyStimulus();
    keycode = 32'h0000_002C;
    applyStimulus();
    keycode = 32'h0000_2C50;
    applyStimulus(); applyStimulus();
    checkOutput("coalesce_drops", 32'(drop_count), STATS ? 32'd1 : 32'd0);
    checkOutput("pre_reset_cmd", 32'(move_cmd), 32'(CMD_HARD_DROP));
    reset = 1'b1;
    keycode = '0;
    applyStimulus();
    reset = 1'b0;
    checkOutput("midreset_valid", 32'(move_valid), 32'd0);
    checkOutput("midreset_cmd", 32'(move_cmd), 32'(CMD_NONE));
    checkOutput("midreset_drops", 32'(drop_count), 32'd0);
    move_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput("pending_cleared", 32'(move_valid), 32'd0);
    end

    // Randomized traffic against the model.
    doReset();
    phase = 0;
    fperiod = 4;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 39) == 0) keycode = randomKeys();
      phase++;
      if (phase >= fperiod) begin phase = 0; fperiod = $urandom_range(3, 6); end
      frame_vs = (phase < 2);
      move_ready = ($urandom_range(0, 9) < 7);
      piece_locked = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 99) == 0) level = 5'($urandom_range(0, 31));
      reset = ($urandom_range(0, 499) == 0);
      applyStimulus();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
